// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for data_mem_arbiter: core load/store port, external loader/debug port and data-memory port.
interface data_mem_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    input  mem_rdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    output ext_gnt, ext_rdata, ext_rvalid,
    output mem_we, mem_re, mem_addr, mem_wdata, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    output mem_rdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    input  ext_gnt, ext_rdata, ext_rvalid,
    input  mem_we, mem_re, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester (nRISC core / external port) arbiter for the single data-memory port, one access in flight.
// Define ARB_CPU_PRIO_EN for fixed CPU priority; default build uses round-robin on ties.
module data_mem_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 1
) (
  input logic               CLK,
  input logic               RESET,
  data_mem_arbiter_if.slave bus
);
  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {WIN_CPU, WIN_EXT} who_t;

  localparam logic [1:0] LAT = 2'(READ_LAT);

  state_t            state_reg, state_next;
  who_t              owner_reg, owner_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0] ext_rdata_reg, ext_rdata_next;
  logic              cpu_rvalid_reg, cpu_rvalid_next;
  logic              ext_rvalid_reg, ext_rvalid_next;
`ifndef ARB_CPU_PRIO_EN
  who_t              last_winner_reg, last_winner_next;
`endif

  logic              cpu_cand;
  logic              cpu_issue;
  logic              ext_issue;
  logic              issue;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg      <= IDLE;
      owner_reg      <= WIN_CPU;
      cnt_reg        <= 2'd0;
      cpu_rdata_reg  <= '0;
      ext_rdata_reg  <= '0;
      cpu_rvalid_reg <= 1'b0;
      ext_rvalid_reg <= 1'b0;
`ifndef ARB_CPU_PRIO_EN
      last_winner_reg <= WIN_EXT;
`endif
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      cnt_reg        <= cnt_next;
      cpu_rdata_reg  <= cpu_rdata_next;
      ext_rdata_reg  <= ext_rdata_next;
      cpu_rvalid_reg <= cpu_rvalid_next;
      ext_rvalid_reg <= ext_rvalid_next;
`ifndef ARB_CPU_PRIO_EN
      last_winner_reg <= last_winner_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    cnt_next        = cnt_reg;
    cpu_rdata_next  = cpu_rdata_reg;
    ext_rdata_next  = ext_rdata_reg;
    cpu_rvalid_next = 1'b0;
    ext_rvalid_next = 1'b0;
`ifndef ARB_CPU_PRIO_EN
    last_winner_next = last_winner_reg;
`endif
    cpu_issue = 1'b0;
    ext_issue = 1'b0;
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    // A CPU request still high in its own rvalid cycle is the read just served, not a new access.
    cpu_cand  = bus.cpu_req && !cpu_rvalid_reg;

    case (state_reg)
      IDLE: begin
        if (!RESET) begin
`ifdef ARB_CPU_PRIO_EN
          cpu_issue = cpu_cand;
          ext_issue = bus.ext_req && !cpu_cand;
`else
          if (cpu_cand && bus.ext_req) begin
            cpu_issue = (last_winner_reg == WIN_EXT);
            ext_issue = (last_winner_reg == WIN_CPU);
          end else begin
            cpu_issue = cpu_cand;
            ext_issue = bus.ext_req;
          end
`endif
        end
      end
      RD_WAIT: begin
        cnt_next = cnt_reg - 2'd1;
        if (cnt_reg == 2'd1) begin
          state_next = IDLE;
          if (owner_reg == WIN_CPU) begin
            cpu_rdata_next  = bus.mem_rdata;
            cpu_rvalid_next = 1'b1;
          end else begin
            ext_rdata_next  = bus.mem_rdata;
            ext_rvalid_next = 1'b1;
          end
        end
      end
    endcase

    if (cpu_issue) begin
      we_sel    = bus.cpu_we;
      addr_sel  = bus.cpu_addr;
      wdata_sel = bus.cpu_wdata;
    end else if (ext_issue) begin
      we_sel    = bus.ext_we;
      addr_sel  = bus.ext_addr;
      wdata_sel = bus.ext_wdata;
    end
    issue = cpu_issue || ext_issue;

    if (issue) begin
`ifndef ARB_CPU_PRIO_EN
      last_winner_next = cpu_issue ? WIN_CPU : WIN_EXT;
`endif
      if (!we_sel) begin
        state_next = RD_WAIT;
        owner_next = cpu_issue ? WIN_CPU : WIN_EXT;
        cnt_next   = LAT;
      end
    end
  end

  assign bus.mem_we     = issue && we_sel;
  assign bus.mem_re     = issue && !we_sel;
  assign bus.mem_addr   = addr_sel;
  assign bus.mem_wdata  = wdata_sel;
  assign bus.ext_gnt    = ext_issue;
  assign bus.cpu_stall  = bus.cpu_req && !((cpu_issue && bus.cpu_we) || cpu_rvalid_reg);
  assign bus.cpu_rdata  = cpu_rdata_reg;
  assign bus.ext_rdata  = ext_rdata_reg;
  assign bus.cpu_rvalid = cpu_rvalid_reg;
  assign bus.ext_rvalid = ext_rvalid_reg;
  assign bus.busy       = (state_reg == RD_WAIT);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: vector table for issue-cycle behaviour, scoreboard for read data.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int READ_LAT = 1;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  data_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  data_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(READ_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  // Memory model answering the DUT's memory port; junk on non-read cycles catches mistimed captures.
  logic [7:0] mem_array [256];
  logic [7:0] rd_pipe [READ_LAT];
  always @(posedge CLK) begin
    if (bus.mem_we) mem_array[bus.mem_addr] <= bus.mem_wdata;
    rd_pipe[0] <= bus.mem_re ? mem_array[bus.mem_addr] : 8'hEE;
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[READ_LAT-1];

  logic [7:0] shadow [256];
  logic [7:0] cpu_q [$];
  logic [7:0] ext_q [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every rvalid pops the value pushed when that read was driven.
  always @(negedge CLK) begin
    logic [7:0] exp_d;
    if (bus.cpu_rvalid === 1'b1) begin
      checks++;
      if (cpu_q.size() == 0) begin
        failures++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid=1 data=0x%0h expected no pending read", bus.cpu_rdata);
      end else begin
        exp_d = cpu_q.pop_front();
        if (bus.cpu_rdata !== exp_d) begin
          failures++;
          $display("FAIL cpu_rdata: got 0x%0h expected 0x%0h", bus.cpu_rdata, exp_d);
        end
        $display("cpu read returned 0x%0h (expected 0x%0h)", bus.cpu_rdata, exp_d);
      end
    end
    if (bus.ext_rvalid === 1'b1) begin
      checks++;
      if (ext_q.size() == 0) begin
        failures++;
        $display("FAIL ext_rvalid_unexpected: got rvalid=1 data=0x%0h expected no pending read", bus.ext_rdata);
      end else begin
        exp_d = ext_q.pop_front();
        if (bus.ext_rdata !== exp_d) begin
          failures++;
          $display("FAIL ext_rdata: got 0x%0h expected 0x%0h", bus.ext_rdata, exp_d);
        end
        $display("ext read returned 0x%0h (expected 0x%0h)", bus.ext_rdata, exp_d);
      end
    end
  end

  typedef struct {
    logic       creq, cwe;
    logic [7:0] caddr, cwd;
    logic       ereq, ewe;
    logic [7:0] eaddr, ewd;
    logic       x_we, x_re;
    logic [7:0] x_addr, x_wd;
    logic       x_gnt, x_stall;
  } vec_t;

  function automatic vec_t mk(input logic creq, cwe, input logic [7:0] caddr, cwd,
                              input logic ereq, ewe, input logic [7:0] eaddr, ewd,
                              input logic x_we, x_re, input logic [7:0] x_addr, x_wd,
                              input logic x_gnt, x_stall);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.ereq = ereq; v.ewe = ewe; v.eaddr = eaddr; v.ewd = ewd;
    v.x_we = x_we; v.x_re = x_re; v.x_addr = x_addr; v.x_wd = x_wd;
    v.x_gnt = x_gnt; v.x_stall = x_stall;
    return v;
  endfunction

  task automatic drive(input logic creq, cwe, input logic [7:0] caddr, cwd,
                       input logic ereq, ewe, input logic [7:0] eaddr, ewd);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.ext_req = ereq; bus.ext_we = ewe; bus.ext_addr = eaddr; bus.ext_wdata = ewd;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Single read by one requester from an idle arbiter; the scoreboard checks the returned data.
  task automatic do_read(input logic is_ext, input logic [7:0] addr);
    if (is_ext) begin
      drive(0, 0, 8'h00, 8'h00, 1, 0, addr, 8'h00);
      ext_q.push_back(shadow[addr]);
    end else begin
      drive(1, 0, addr, 8'h00, 0, 0, 8'h00, 8'h00);
      cpu_q.push_back(shadow[addr]);
    end
    @(negedge CLK);
    chk("rd_issue_mem_re", bus.mem_re, 1);
    chk("rd_issue_addr", bus.mem_addr, addr);
    chk("rd_issue_gnt", bus.ext_gnt, is_ext);
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k <= READ_LAT; k++) tick();
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0);
    vecs[1] = mk(1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, 1,0,8'h10,8'h5A, 0,0);
    vecs[2] = mk(0,0,8'h00,8'h00, 1,1,8'h20,8'h33, 1,0,8'h20,8'h33, 1,0);
    vecs[3] = mk(1,1,8'h01,8'h11, 1,1,8'h02,8'h22, 1,0,8'h01,8'h11, 0,0);
`ifdef ARB_CPU_PRIO_EN
    vecs[4] = mk(1,1,8'h03,8'h13, 1,1,8'h04,8'h24, 1,0,8'h03,8'h13, 0,0);
`else
    vecs[4] = mk(1,1,8'h03,8'h13, 1,1,8'h04,8'h24, 1,0,8'h04,8'h24, 1,1);
`endif
    vecs[5] = mk(1,1,8'h05,8'h15, 1,1,8'h06,8'h26, 1,0,8'h05,8'h15, 0,0);
    vecs[6] = mk(0,0,8'h00,8'h00, 1,1,8'h07,8'h27, 1,0,8'h07,8'h27, 1,0);
    vecs[7] = mk(1,1,8'h30,8'hC3, 0,0,8'h00,8'h00, 1,0,8'h30,8'hC3, 0,0);
    vecs[8] = mk(0,1,8'h55,8'hAA, 0,1,8'h66,8'hBB, 0,0,8'h00,8'h00, 0,0);

    // Reset state
    RESET = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    tick();
    @(negedge CLK);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_ext_rdata", bus.ext_rdata, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_ext_rvalid", bus.ext_rvalid, 0);
    chk("rst_ext_gnt", bus.ext_gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_re", bus.mem_re, 0);
    tick();
    RESET = 1'b0;

    // Issue-cycle vectors (writes and idle keep the arbiter in IDLE)
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
            vecs[i].ereq, vecs[i].ewe, vecs[i].eaddr, vecs[i].ewd);
      @(negedge CLK);
      chk($sformatf("v%0d_mem_we", i), bus.mem_we, vecs[i].x_we);
      chk($sformatf("v%0d_mem_re", i), bus.mem_re, vecs[i].x_re);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].x_addr);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].x_wd);
      chk($sformatf("v%0d_ext_gnt", i), bus.ext_gnt, vecs[i].x_gnt);
      chk($sformatf("v%0d_cpu_stall", i), bus.cpu_stall, vecs[i].x_stall);
      $display("vec %0d: mem_we=%0b mem_re=%0b addr=0x%0h wdata=0x%0h gnt=%0b stall=%0b",
               i, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, bus.ext_gnt, bus.cpu_stall);
      if (vecs[i].x_we) shadow[vecs[i].x_addr] = vecs[i].x_wd;
      tick();
    end

    // CPU read of 0x10: stalled through the wait, rvalid at issue+READ_LAT+1
    drive(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    cpu_q.push_back(shadow[8'h10]);
    @(negedge CLK);
    chk("a_issue_mem_re", bus.mem_re, 1);
    chk("a_issue_mem_we", bus.mem_we, 0);
    chk("a_issue_addr", bus.mem_addr, 8'h10);
    chk("a_issue_stall", bus.cpu_stall, 1);
    tick();
    for (int k = 0; k < READ_LAT; k++) begin
      @(negedge CLK);
      chk("a_wait_mem_re", bus.mem_re, 0);
      chk("a_wait_busy", bus.busy, 1);
      chk("a_wait_stall", bus.cpu_stall, 1);
      chk("a_wait_rvalid", bus.cpu_rvalid, 0);
      tick();
    end
    @(negedge CLK);
    chk("a_rvalid", bus.cpu_rvalid, 1);
    chk("a_rvalid_stall", bus.cpu_stall, 0);
    chk("a_rvalid_busy", bus.busy, 0);
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("a_rvalid_one_cycle", bus.cpu_rvalid, 0);
    chk("a_rdata_hold", bus.cpu_rdata, 8'h5A);
    tick();

    // CPU read in flight, ext read 0x30 waits and issues in the CPU rvalid cycle
    drive(1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00);
    cpu_q.push_back(shadow[8'h01]);
    @(negedge CLK);
    chk("b_cpu_issue", bus.mem_re, 1);
    chk("b_cpu_addr", bus.mem_addr, 8'h01);
    tick();
    drive(1, 0, 8'h01, 8'h00, 1, 0, 8'h30, 8'h00);
    ext_q.push_back(shadow[8'h30]);
    for (int k = 0; k < READ_LAT; k++) begin
      @(negedge CLK);
      chk("b_wait_mem_re", bus.mem_re, 0);
      chk("b_wait_gnt", bus.ext_gnt, 0);
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h30, 8'h00);
    @(negedge CLK);
    chk("b_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("b_ext_mem_re", bus.mem_re, 1);
    chk("b_ext_addr", bus.mem_addr, 8'h30);
    chk("b_ext_gnt", bus.ext_gnt, 1);
    tick();
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < READ_LAT; k++) begin
      @(negedge CLK);
      chk("b_ext_busy", bus.busy, 1);
      tick();
    end
    @(negedge CLK);
    chk("b_ext_rvalid", bus.ext_rvalid, 1);
    chk("b_cpu_rdata_hold", bus.cpu_rdata, 8'h11);
    tick();

    // RESET during a CPU read: aborted, no rvalid, everything back to reset values
    drive(1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00);
    @(negedge CLK);
    chk("c_issue", bus.mem_re, 1);
    tick();
    RESET = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("c_busy", bus.busy, 0);
    chk("c_cpu_rdata", bus.cpu_rdata, 0);
    chk("c_ext_rdata", bus.ext_rdata, 0);
    chk("c_mem_re", bus.mem_re, 0);
    chk("c_stall", bus.cpu_stall, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("c_no_rvalid", bus.cpu_rvalid, 0);
      tick();
    end

    // Contention straight after reset: CPU writes each cycle, ext write held
    for (int i = 0; i < 9; i++) begin
      logic       exp_gnt;
      logic [7:0] exp_addr;
      if (i == 8) begin
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'h22);
        exp_gnt = 1'b1;
      end else begin
        drive(1, 1, 8'h40 + 8'(i), 8'(i), 1, 1, 8'h02, 8'h22);
`ifdef ARB_CPU_PRIO_EN
        exp_gnt = 1'b0;
`else
        exp_gnt = (i % 2 == 1);
`endif
      end
      exp_addr = exp_gnt ? 8'h02 : 8'h40 + 8'(i);
      @(negedge CLK);
      chk($sformatf("d%0d_ext_gnt", i), bus.ext_gnt, exp_gnt);
      chk($sformatf("d%0d_mem_addr", i), bus.mem_addr, exp_addr);
      chk($sformatf("d%0d_cpu_stall", i), bus.cpu_stall, (i != 8) && exp_gnt);
      $display("arb cycle %0d: gnt=%0b addr=0x%0h stall=%0b", i, bus.ext_gnt, bus.mem_addr, bus.cpu_stall);
      shadow[exp_addr] = exp_gnt ? 8'h22 : 8'(i);
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    tick();

    // Read back what the contention phase wrote
    do_read(1'b0, 8'h02);
    do_read(1'b1, 8'h46);
    do_read(1'b0, 8'h07);
    for (int k = 0; k < 3; k++) tick();

    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("ext_q_drained", ext_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
